// File: rtl/rx_serie_paralelo_pkg.sv
// Shared K-symbol constants and receive-alignment state encoding; no logic, no latency.
// Also used by the downstream K28.5 detector.
package rx_serie_paralelo_pkg;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] STP  = 8'hFB;
    localparam logic [7:0] SDP  = 8'h5C;
    localparam logic [7:0] SKP  = 8'h1C;
    localparam logic [7:0] END  = 8'hFD;
    localparam logic [7:0] EDB  = 8'hFE;
    localparam logic [7:0] FTS  = 8'h3C;
    localparam logic [7:0] IDLE = 8'h7C;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_com_match.sv
// Combinational comma comparator on the candidate byte; zero latency, no backpressure.
// With RX_POLARITY_INV_EN defined it also flags the bitwise-inverted comma.
module rx_com_match
    import rx_serie_paralelo_pkg::*;
#(
    parameter logic [7:0] COM_SYM = COM
) (
    input  logic [7:0] i_cand,
    output logic       o_is_com,
    output logic       o_is_inv
);

    assign o_is_com = (i_cand == COM_SYM);

`ifdef RX_POLARITY_INV_EN
    assign o_is_inv = (i_cand == ~COM_SYM);
`else
    assign o_is_inv = 1'b0;
`endif

endmodule

// File: rtl/rx_serie_paralelo.sv
// Serial-to-byte deserializer with comma alignment and lock tracking; 1-cycle latency after a byte's last bit.
// No backpressure: enb gates bit sampling; optional RX_POLARITY_INV_EN adds inverted-comma polarity correction.
module rx_serie_paralelo #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       rx_serial,
    output logic [7:0] rx_DataE,
    output logic       byte_valid,
    output logic       sync,
    output logic       lock_lost
);
    import rx_serie_paralelo_pkg::*;

    rx_state_e  r_state, w_state_nxt;
    logic [7:0] r_sr, w_cand;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0] r_com_cnt, w_com_cnt_nxt;
    logic [7:0] r_gap_cnt, w_gap_cnt_nxt;
    logic [7:0] r_data, w_data_nxt;
    logic       r_vld, w_vld_nxt;
    logic       r_sync;
    logic       r_lost, w_lost_nxt;
    logic       w_bit, w_is_com, w_is_inv, w_hunt_match;
    logic       w_boundary, w_com_done, w_gap_over;

`ifdef RX_POLARITY_INV_EN
    logic r_pol;

    // Polarity is latched on an inverted-comma hit and forgotten whenever alignment is abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pol <= 1'b0;
        end else if (enb) begin
            if (w_state_nxt == HUNT)
                r_pol <= 1'b0;
            else if (r_state == HUNT && w_is_inv)
                r_pol <= 1'b1;
        end
    end

    assign w_bit = rx_serial ^ r_pol;
`else
    assign w_bit = rx_serial;
`endif

    assign w_cand       = {r_sr[6:0], w_bit};
    assign w_hunt_match = w_is_com | w_is_inv;
    assign w_boundary   = (r_bit_cnt == 3'd7);
    assign w_com_done   = ((int'(r_com_cnt) + 1) == LOCK_COUNT);
    assign w_gap_over   = ((int'(r_gap_cnt) + 1) > MAX_GAP);

    rx_com_match #(.COM_SYM(COM)) u_com_match (
        .i_cand   (w_cand),
        .o_is_com (w_is_com),
        .o_is_inv (w_is_inv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= HUNT;
            r_sr      <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_com_cnt <= 4'd0;
            r_gap_cnt <= 8'd0;
            r_data    <= 8'h00;
            r_vld     <= 1'b0;
            r_sync    <= 1'b0;
            r_lost    <= 1'b0;
        end else if (enb) begin
            r_state   <= w_state_nxt;
            r_sr      <= w_cand;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_com_cnt <= w_com_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_data    <= w_data_nxt;
            r_vld     <= w_vld_nxt;
            r_sync    <= (w_state_nxt == LOCKED);
            r_lost    <= w_lost_nxt;
        end else begin
            r_vld  <= 1'b0;
            r_lost <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HUNT: begin
                if (w_hunt_match)
                    w_state_nxt = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
            end
            VERIFY: begin
                if (w_boundary) begin
                    if (w_is_com) begin
                        if (w_com_done)
                            w_state_nxt = LOCKED;
                    end else if (w_gap_over) begin
                        w_state_nxt = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (w_boundary && !w_is_com && w_gap_over)
                    w_state_nxt = HUNT;
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_comb begin
        w_bit_cnt_nxt = r_bit_cnt;
        w_com_cnt_nxt = r_com_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_data_nxt    = r_data;
        w_vld_nxt     = 1'b0;
        w_lost_nxt    = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_hunt_match) begin
                    w_bit_cnt_nxt = 3'd0;
                    w_com_cnt_nxt = 4'd1;
                    w_gap_cnt_nxt = 8'd0;
                    if (LOCK_COUNT == 1) begin
                        w_data_nxt = COM;
                        w_vld_nxt  = 1'b1;
                    end
                end
            end
            VERIFY: begin
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_com_cnt_nxt = sat_inc4(r_com_cnt);
                        w_gap_cnt_nxt = 8'd0;
                        if (w_com_done) begin
                            w_data_nxt = w_cand;
                            w_vld_nxt  = 1'b1;
                        end
                    end else begin
                        w_gap_cnt_nxt = sat_inc8(r_gap_cnt);
                        if (w_gap_over)
                            w_com_cnt_nxt = 4'd0;
                    end
                end
            end
            LOCKED: begin
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    // The byte that exhausts the gap budget is still handed downstream.
                    w_data_nxt = w_cand;
                    w_vld_nxt  = 1'b1;
                    if (w_is_com) begin
                        w_gap_cnt_nxt = 8'd0;
                    end else begin
                        w_gap_cnt_nxt = sat_inc8(r_gap_cnt);
                        if (w_gap_over) begin
                            w_lost_nxt    = 1'b1;
                            w_com_cnt_nxt = 4'd0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign rx_DataE   = r_data;
    assign byte_valid = r_vld;
    assign sync       = r_sync;
    assign lock_lost  = r_lost;

endmodule

// File: tb/tb_rx_serie_paralelo.sv
// Bench for rx_serie_paralelo: scenario tasks compare the DUT against a bit-history reference model.
module tb_rx_serie_paralelo;

    localparam logic [7:0] COM        = 8'hBC;
    localparam int         LOCK_COUNT = 4;
    localparam int         MAX_GAP    = 64;
`ifdef RX_POLARITY_INV_EN
    localparam bit POL_EN = 1'b1;
`else
    localparam bit POL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, enb, rx_serial;
    logic [7:0] rx_DataE;
    logic       byte_valid, sync, lock_lost;

    int total = 0;
    int bad   = 0;

    // Reference model: alignment tracked as "bits since the comma hit", counts as plain integers.
    int         m_mode;      // 0 hunting, 1 verifying, 2 locked
    int         m_since, m_coms, m_gap;
    logic [7:0] m_win;
    logic       m_pol;
    logic [7:0] exp_dat;
    logic       exp_vld, exp_sync, exp_lost;

    always #5 clk = ~clk;

    rx_serie_paralelo #(.COM(COM), .LOCK_COUNT(LOCK_COUNT), .MAX_GAP(MAX_GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .rx_serial  (rx_serial),
        .rx_DataE   (rx_DataE),
        .byte_valid (byte_valid),
        .sync       (sync),
        .lock_lost  (lock_lost)
    );

    task automatic model_step(input logic b, input logic e, input logic r);
        logic [7:0] c;
        if (r) begin
            m_mode = 0; m_since = 0; m_coms = 0; m_gap = 0; m_win = 8'h00; m_pol = 1'b0;
            exp_dat = 8'h00; exp_vld = 1'b0; exp_sync = 1'b0; exp_lost = 1'b0;
        end else if (!e) begin
            exp_vld  = 1'b0;
            exp_lost = 1'b0;
        end else begin
            c = {m_win[6:0], b ^ m_pol};
            m_win = c;
            exp_vld = 1'b0;
            exp_lost = 1'b0;
            if (m_mode == 0) begin
                if (c == COM || (POL_EN && c == ~COM)) begin
                    m_pol = (c != COM);
                    m_since = 0; m_coms = 1; m_gap = 0;
                    m_mode = (LOCK_COUNT == 1) ? 2 : 1;
                    if (m_mode == 2) begin exp_dat = COM; exp_vld = 1'b1; end
                end
            end else begin
                m_since++;
                if (m_since % 8 == 0) begin
                    if (m_mode == 2) begin exp_dat = c; exp_vld = 1'b1; end
                    if (c == COM) begin
                        m_gap = 0;
                        if (m_mode == 1) begin
                            m_coms = (m_coms < 15) ? m_coms + 1 : 15;
                            if (m_coms == LOCK_COUNT) begin
                                m_mode = 2; exp_dat = c; exp_vld = 1'b1;
                            end
                        end
                    end else begin
                        m_gap = (m_gap < 255) ? m_gap + 1 : 255;
                        if (m_gap > MAX_GAP) begin
                            if (m_mode == 2) exp_lost = 1'b1;
                            m_mode = 0; m_coms = 0; m_pol = 1'b0;
                        end
                    end
                end
            end
            exp_sync = (m_mode == 2);
        end
    endtask

    task automatic send_bit(input logic b, input logic e);
        rx_serial = b; enb = e; rst = 1'b0;
        model_step(b, e, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic apply_rst(input logic e);
        rx_serial = 1'b0; enb = e; rst = 1'b1;
        model_step(1'b0, e, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_rst(1'b1);
        total++;
        if ({rx_DataE, byte_valid, sync, lock_lost} !== {8'h00, 3'b000}) begin
            bad++;
            $display("FAIL reset_state: got data=%h vld=%b sync=%b lost=%b want 00/0/0/0",
                     rx_DataE, byte_valid, sync, lock_lost);
        end
    endtask

    task automatic test_lock();
        logic [34:0] pat;
        pat = {3'b101, COM, COM, COM, COM};
        for (int i = 34; i >= 0; i--) begin
            send_bit(pat[i], 1'b1);
            total++;
            if ({byte_valid, sync, lock_lost} !== {i == 0, i == 0, 1'b0}) begin
                bad++;
                $display("FAIL lock_seq bit %0d: got vld=%b sync=%b lost=%b want vld=%b sync=%b lost=0",
                         34 - i, byte_valid, sync, lock_lost, i == 0, i == 0);
            end
        end
        total++;
        if (rx_DataE !== COM) begin
            bad++;
            $display("FAIL lock_first_byte: got %h want %h", rx_DataE, COM);
        end
    endtask

    task automatic test_data();
        logic [7:0] bytes [2];
        bytes[0] = 8'h5C; bytes[1] = 8'hFD;
        for (int k = 0; k < 2; k++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(bytes[k][i], 1'b1);
                total++;
                if (byte_valid !== (i == 0) || sync !== 1'b1 || byte_valid !== exp_vld) begin
                    bad++;
                    $display("FAIL data_strobe byte %0d bit %0d: got vld=%b sync=%b want vld=%b sync=1",
                             k, 7 - i, byte_valid, sync, i == 0);
                end
            end
            total++;
            if (rx_DataE !== bytes[k]) begin
                bad++;
                $display("FAIL data_byte %0d: got %h want %h", k, rx_DataE, bytes[k]);
            end
        end
    endtask

    task automatic test_gap_loss();
        for (int i = 7; i >= 0; i--) send_bit(COM[i], 1'b1);
        for (int k = 0; k < 65; k++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(1'b0, 1'b1);
                total++;
                if (byte_valid !== (i == 0) || lock_lost !== (i == 0 && k == 64) ||
                    sync !== !(i == 0 && k == 64)) begin
                    bad++;
                    $display("FAIL gap_loss byte %0d bit %0d: got vld=%b lost=%b sync=%b",
                             k, 7 - i, byte_valid, lock_lost, sync);
                end
            end
            total++;
            if (rx_DataE !== 8'h00 || exp_dat !== rx_DataE) begin
                bad++;
                $display("FAIL gap_byte %0d: got %h want 00", k, rx_DataE);
            end
        end
        send_bit(1'b0, 1'b1);
        total++;
        if ({lock_lost, sync, byte_valid} !== 3'b000) begin
            bad++;
            $display("FAIL gap_after_loss: got lost=%b sync=%b vld=%b want 000", lock_lost, sync, byte_valid);
        end
    endtask

    task automatic test_enb_toggle();
        logic [7:0] sent[$];
        logic [7:0] got[$];
        logic [7:0] v;
        for (int k = 0; k < 4; k++)
            for (int i = 7; i >= 0; i--) send_bit(COM[i], 1'b1);
        total++;
        if (sync !== 1'b1) begin
            bad++;
            $display("FAIL enb_relock: got sync=%b want 1", sync);
        end
        for (int k = 0; k < 6; k++) begin
            v = 8'($urandom);
            sent.push_back(v);
            for (int i = 7; i >= 0; i--) begin
                send_bit(v[i], 1'b1);
                if (byte_valid) got.push_back(rx_DataE);
                send_bit(1'($urandom), 1'b0);
                total++;
                if (byte_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL enb_off_strobe byte %0d: got vld=%b want 0", k, byte_valid);
                end
            end
        end
        total++;
        if (got.size() != sent.size()) begin
            bad++;
            $display("FAIL enb_count: got %0d bytes want %0d", got.size(), sent.size());
        end
        for (int k = 0; k < sent.size() && k < got.size(); k++) begin
            total++;
            if (got[k] !== sent[k]) begin
                bad++;
                $display("FAIL enb_byte %0d: got %h want %h", k, got[k], sent[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        total++;
        if (sync !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre_sync: got %b want 1", sync);
        end
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b1);
        apply_rst(1'b1);
        total++;
        if ({sync, rx_DataE, byte_valid} !== {1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL midrst_state: got sync=%b data=%h vld=%b want 0/00/0", sync, rx_DataE, byte_valid);
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(COM[i], 1'b1);
                total++;
                if ({byte_valid, sync} !== {2{k == 3 && i == 0}}) begin
                    bad++;
                    $display("FAIL midrst_relock com %0d bit %0d: got vld=%b sync=%b", k, 7 - i, byte_valid, sync);
                end
            end
        end
    endtask

`ifdef RX_POLARITY_INV_EN
    task automatic test_polarity();
        logic [39:0] pat;
        pat = {8'h43, 8'h43, 8'h43, 8'h43, 8'hA3};
        apply_rst(1'b1);
        for (int i = 39; i >= 0; i--) begin
            send_bit(pat[i], 1'b1);
            if (i == 8) begin
                total++;
                if ({byte_valid, sync, rx_DataE} !== {2'b11, COM}) begin
                    bad++;
                    $display("FAIL pol_lock: got vld=%b sync=%b data=%h want 1/1/%h", byte_valid, sync, rx_DataE, COM);
                end
            end
        end
        total++;
        if ({byte_valid, rx_DataE} !== {1'b1, 8'h5C}) begin
            bad++;
            $display("FAIL pol_data: got vld=%b data=%h want 1/5c", byte_valid, rx_DataE);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] v;
        for (int run = 0; run < 6; run++) begin
            apply_rst(1'b1);
            for (int j = $urandom_range(0, 7); j > 0; j--) send_bit(1'($urandom), 1'b1);
            for (int k = 0; k < 24; k++) begin
                if (k < 4 || $urandom_range(0, 3) == 0) v = COM;
                else v = 8'($urandom);
                for (int i = 7; i >= 0; i--) begin
                    while ($urandom_range(0, 9) == 0) begin
                        send_bit(1'($urandom), 1'b0);
                        total++;
                        if ({byte_valid, lock_lost, sync, rx_DataE} !== {exp_vld, exp_lost, exp_sync, exp_dat}) begin
                            bad++;
                            $display("FAIL rand_idle run %0d: got %b%b%b/%h want %b%b%b/%h", run,
                                     byte_valid, lock_lost, sync, rx_DataE, exp_vld, exp_lost, exp_sync, exp_dat);
                        end
                    end
                    send_bit(v[i], 1'b1);
                    total++;
                    if ({byte_valid, lock_lost, sync, rx_DataE} !== {exp_vld, exp_lost, exp_sync, exp_dat}) begin
                        bad++;
                        $display("FAIL rand_bit run %0d byte %0d: got %b%b%b/%h want %b%b%b/%h", run, k,
                                 byte_valid, lock_lost, sync, rx_DataE, exp_vld, exp_lost, exp_sync, exp_dat);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; rx_serial = 1'b0;
        test_reset();
        test_lock();
        test_data();
        test_gap_loss();
        test_enb_toggle();
        test_mid_reset();
`ifdef RX_POLARITY_INV_EN
        test_polarity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_serie_paralelo.md
Name: rx_serie_paralelo

Overview:
Receive-path deserializer that sits directly upstream of the K28.5 detector. It accepts a 1-bit serial stream, hunts for the COM symbol (8'hBC) at any bit offset, and verifies the byte alignment over several COMs before declaring symbol lock. Once locked, it presents aligned bytes plus a one-cycle valid strobe on the detector's byte input.

Parameters:
COM, 8'hBC, comma symbol used for alignment
LOCK_COUNT, 4, aligned COMs required to declare lock (range 1..15)
MAX_GAP, 64, consecutive aligned non-COM bytes tolerated before lock is dropped (range 1..255)

Ports:
clk  input  1  clock; one serial bit per enabled cycle
rst  input  1  reset, synchronous, active-high
enb  input  1  bit enable; when low, all state holds
rx_serial  input  1  serial data, MSB of each byte first
rx_DataE  output  8  aligned byte, feeds the detector byte input
byte_valid  output  1  one-cycle strobe; rx_DataE updated this cycle
sync  output  1  high while in LOCKED
lock_lost  output  1  one-cycle pulse on a LOCKED->HUNT transition

Behaviour:
- Reset (rst=1 at posedge):
  - state=HUNT; shift register, bit_cnt, com_cnt and gap_cnt = 0.
  - rx_DataE=8'h00; byte_valid, sync and lock_lost = 0.
  - Reset has priority over enb and takes effect mid-byte or mid-lock without any flush.
- enb=0: all registers hold, except byte_valid and lock_lost, which are forced to 0.
- Candidate byte: cand = {sr[6:0], rx_serial}. On every enabled cycle, sr <= cand.
- HUNT:
  - Checked on every enabled cycle. If cand==COM: bit_cnt<=0, com_cnt<=1, gap_cnt<=0.
  - Next state is VERIFY, or LOCKED if LOCK_COUNT==1. In the LOCKED case, also set rx_DataE<=COM and byte_valid<=1.
- VERIFY and LOCKED:
  - bit_cnt increments mod 8.
  - Boundary = enabled cycle with bit_cnt==7. The first boundary occurs 8 enabled cycles after the HUNT match.
- VERIFY boundary:
  - cand==COM: com_cnt++ and gap_cnt<=0. When com_cnt+1==LOCK_COUNT: go to LOCKED, set rx_DataE<=cand and byte_valid<=1, so the locking COM is delivered.
  - cand!=COM: gap_cnt++. If gap_cnt+1>MAX_GAP: go to HUNT with com_cnt=0, no pulse.
- LOCKED boundary:
  - Always set rx_DataE<=cand and byte_valid<=1.
  - cand==COM: gap_cnt<=0; otherwise gap_cnt++.
  - If gap_cnt+1>MAX_GAP: go to HUNT and pulse lock_lost. That byte is still delivered.
- Timing and flags:
  - Latency: a byte's last bit is sampled at edge N; rx_DataE/byte_valid are valid after edge N.
  - sync is registered: it goes high with the first byte_valid and drops with lock_lost.
- COM seen off-boundary in VERIFY/LOCKED: ignored, no realignment. Only HUNT realigns.
- Counter rules: com_cnt is 4 bits and gap_cnt is 8 bits. Both saturate and never wrap.

Optional Feature:
- Macro RX_POLARITY_INV_EN.
- When defined:
  - HUNT also matches cand==~COM (8'h43). On that match, a polarity register is set, and all later bits are inverted before entering sr.
  - The polarity register is cleared by rst and on any transition to HUNT.
- When undefined: no inversion logic; 8'h43 is not a match.

Decomposition:
- Shared package: K-symbol constants (COM, STP, SDP, SKP, END, EDB, FTS, IDLE) and a state encoding (HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2).
- The detector uses the same constants.
- One natural sub-module: rx_com_match, a combinational COM/inverted-COM comparator on cand. The FSM and counters stay in the top module.

Test Plan:
1. Reset then 3 junk bits 101, followed by 4x 8'hBC MSB-first -> sync=0 through 3 COMs; first byte_valid with rx_DataE=8'hBC on the boundary of the 4th COM; sync=1.
2. Locked, then send 8'h5C, 8'hFD -> byte_valid pulses every 8th enabled cycle; rx_DataE=8'h5C then 8'hFD, 1-cycle latency after the last bit.
3. Locked, then 65 consecutive 8'h00 bytes (MAX_GAP=64) -> 64 bytes delivered normally; on the 65th, byte_valid=1 and lock_lost=1 for one cycle, sync=0, state=HUNT.
4. enb toggled 0/1 every cycle during lock -> bytes identical to the enb=1 run; byte_valid only on enabled cycles; nothing is lost or duplicated.
5. Assert rst for one cycle mid-byte while locked -> next cycle: sync=0, rx_DataE=8'h00, byte_valid=0; relock requires 4 fresh COMs.
6. (RX_POLARITY_INV_EN) send 4x 8'h43 then inverted 8'h5C (8'hA3) -> lock achieved; rx_DataE=8'hBC then 8'h5C.
